// File: rtl/i2c_arbiter_if.sv
// ---------------------------------------------------------------------------
// i2c_arbiter_if
//
// Handshake bundle between the arbiter and the shared I2C master of the
// HDMI transmitter control path.
//
//   m_data   24  {slave addr, sub addr, data} presented to I2C_DATA
//   m_start   1  request the master to run one transfer
//   m_end     1  master idle indication; low while a transfer runs
//   m_ack     1  master acknowledge status, 1 = NACK, valid when m_end rises
//
// Modports:
//   master : the arbiter side (drives data/start, observes end/ack)
//   slave  : the I2C master side (observes data/start, drives end/ack)
// ---------------------------------------------------------------------------
interface i2c_arbiter_if;
  logic [23:0] m_data;
  logic        m_start;
  logic        m_end;
  logic        m_ack;

  modport master (
    output m_data,
    output m_start,
    input  m_end,
    input  m_ack
  );

  modport slave (
    input  m_data,
    input  m_start,
    output m_end,
    output m_ack
  );
endinterface

// File: rtl/i2c_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_arbiter
//
// Shares one I2C master between two requesters: requester 0 is the boot-time
// register-table sequencer, requester 1 the runtime path (HPD re-init,
// video-mode and audio-rate updates). Requests are granted round-robin; a
// NACKed transfer is retried up to RETRIES extra times, and an attempt that
// runs longer than TIMEOUT cycles is abandoned. Each granted transfer ends in
// exactly one req_done pulse to its owner with req_err / req_tmo status.
//
// Parameters:
//   RETRIES   extra attempts after a NACK before reporting an error (0..15)
//   TIMEOUT   cycles allowed per attempt, from m_start rising to m_end high
//
// Ports:
//   iCLK, iRST_N         clock, asynchronous active-low reset
//   req_valid[1:0]       per-requester request level, held until granted
//   req0_data, req1_data 24-bit transfer descriptors, stable while valid
//   req_grant[1:0]       one-cycle pulse: descriptor captured
//   req_done[1:0]        one-cycle completion pulse to the owner
//   req_err, req_tmo     completion status, held until the next req_done
//   busy                 high from grant until completion / drain finished
//   owner                index of the current or most recent grantee
//   err_cnt              saturating count of error completions
//   m_if                 handshake to the shared I2C master
// ---------------------------------------------------------------------------
module i2c_arbiter #(
  parameter int unsigned RETRIES = 3,
  parameter int unsigned TIMEOUT = 2_000_000
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic [1:0]           req_valid,
  input  logic [23:0]          req0_data,
  input  logic [23:0]          req1_data,
  output logic [1:0]           req_grant,
  output logic [1:0]           req_done,
  output logic                 req_err,
  output logic                 req_tmo,
  output logic                 busy,
  output logic                 owner,
  output logic [7:0]           err_cnt,
  i2c_arbiter_if.master        m_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAP,
    S_DRAIN
  } state_e;

  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(RETRIES);

  state_e      state_q,   state_d;
  logic        owner_q,   owner_d;
  logic [23:0] m_data_q,  m_data_d;
  logic        m_start_q, m_start_d;
  logic [1:0]  grant_q,   grant_d;
  logic [1:0]  done_q,    done_d;
  logic        err_q,     err_d;
  logic        tmo_q,     tmo_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [3:0]  retry_q,   retry_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  // Decision terms shared by the next-state and output processes so the
  // two can never disagree about which event fired this cycle.
  logic winner;
  logic do_grant;
  logic tmo_hit;
  logic tmo_fire;
  logic wait_end;
  logic do_retry;
  logic do_finish;

  // On a tie the requester that did not own the bus last time wins.
  assign winner    = (req_valid == 2'b11) ? ~owner_q : req_valid[1];
  assign do_grant  = (state_q == S_IDLE) && (req_valid != 2'b00);
  assign tmo_hit   = (tmo_cnt_q == TMO_LAST);
  // A master that finishes in the very last allowed cycle still counts as a
  // completed transfer, so END high in WAIT takes priority over the timeout.
  assign tmo_fire  = tmo_hit &&
                     ((state_q == S_START) ||
                      ((state_q == S_WAIT) && !m_if.m_end));
  assign wait_end  = (state_q == S_WAIT) && m_if.m_end;
  assign do_retry  = wait_end && m_if.m_ack && (retry_q < RETRY_MAX);
  assign do_finish = wait_end && !do_retry;

  // -------------------------------------------------------------------------
  // State register and datapath flops
  // -------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b1;
      m_data_q  <= '0;
      m_start_q <= 1'b0;
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
      err_cnt_q <= '0;
      retry_q   <= '0;
      tmo_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // computed from the previous state, independent of statement order.
      state_q   <= state_d;
      owner_q   <= owner_d;
      m_data_q  <= m_data_d;
      m_start_q <= m_start_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      err_cnt_q <= err_cnt_d;
      retry_q   <= retry_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (do_grant) state_d = S_START;
      end
      S_START: begin
        if (tmo_fire)          state_d = S_DRAIN;
        else if (!m_if.m_end)  state_d = S_WAIT;
      end
      S_WAIT: begin
        if (do_retry)       state_d = S_GAP;
        else if (do_finish) state_d = S_IDLE;
        else if (tmo_fire)  state_d = S_DRAIN;
      end
      S_GAP: begin
        state_d = S_START;
      end
      S_DRAIN: begin
        // The master is still busy with the abandoned attempt; no new grant
        // may be issued until it reports END.
        if (m_if.m_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    owner_d   = owner_q;
    m_data_d  = m_data_q;
    m_start_d = m_start_q;
    grant_d   = 2'b00;
    done_d    = 2'b00;
    err_d     = err_q;
    tmo_d     = tmo_q;
    err_cnt_d = err_cnt_q;
    retry_d   = retry_q;
    tmo_cnt_d = tmo_cnt_q;

    if (do_grant) begin
      owner_d   = winner;
      m_data_d  = winner ? req1_data : req0_data;
      grant_d   = winner ? 2'b10 : 2'b01;
      m_start_d = 1'b1;
      retry_d   = '0;
      tmo_cnt_d = '0;
    end

    if ((state_q == S_START) || (state_q == S_WAIT)) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end

    // The master has taken the request once END drops.
    if ((state_q == S_START) && !m_if.m_end) begin
      m_start_d = 1'b0;
    end

    if (do_retry) begin
      retry_d = retry_q + 4'd1;
    end

    if (do_finish) begin
      done_d = owner_q ? 2'b10 : 2'b01;
      err_d  = m_if.m_ack;
      tmo_d  = 1'b0;
      if (m_if.m_ack && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end

    if (tmo_fire) begin
      m_start_d = 1'b0;
      done_d    = owner_q ? 2'b10 : 2'b01;
      err_d     = 1'b1;
      tmo_d     = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end

    // Re-issue the same descriptor after the one-cycle idle gap; each
    // attempt gets a fresh timeout budget.
    if (state_q == S_GAP) begin
      m_start_d = 1'b1;
      tmo_cnt_d = '0;
    end
  end

  assign req_grant    = grant_q;
  assign req_done     = done_q;
  assign req_err      = err_q;
  assign req_tmo      = tmo_q;
  assign busy         = (state_q != S_IDLE);
  assign owner        = owner_q;
  assign err_cnt      = err_cnt_q;
  assign m_if.m_data  = m_data_q;
  assign m_if.m_start = m_start_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_arbiter
//
// Directed bench for i2c_arbiter. A small behavioural I2C master answers each
// START after a programmable number of cycles, optionally NACKing a given
// number of attempts first. Expected values are hand-derived from the
// arbiter's documented timing.
// ---------------------------------------------------------------------------
module tb_i2c_arbiter;

  localparam int unsigned RETRIES = 3;
  localparam int unsigned TIMEOUT = 150;

  localparam logic [23:0] D0 = 24'hA0_10_3C;
  localparam logic [23:0] D1 = 24'h7A_22_81;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic [1:0]  req_valid;
  logic [23:0] req0_data;
  logic [23:0] req1_data;
  logic [1:0]  req_grant;
  logic [1:0]  req_done;
  logic        req_err;
  logic        req_tmo;
  logic        busy;
  logic        owner;
  logic [7:0]  err_cnt;

  i2c_arbiter_if m_if ();

  i2c_arbiter #(
    .RETRIES (RETRIES),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .req_valid (req_valid),
    .req0_data (req0_data),
    .req1_data (req1_data),
    .req_grant (req_grant),
    .req_done  (req_done),
    .req_err   (req_err),
    .req_tmo   (req_tmo),
    .busy      (busy),
    .owner     (owner),
    .err_cnt   (err_cnt),
    .m_if      (m_if)
  );

  initial forever #5 iCLK = ~iCLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Master model controls.
  int lat       = 3;
  int nack_left = 0;

  // Statistics gathered while waiting for a completion.
  int rises;
  int min_low;
  int grants_seen;

  // Behavioural I2C master: drops END one cycle after seeing START, keeps it
  // low for `lat` cycles, then raises END with the ACK/NACK status.
  initial begin
    m_if.m_end = 1'b1;
    m_if.m_ack = 1'b0;
    forever begin
      @(negedge iCLK);
      if (m_if.m_start && m_if.m_end) begin
        m_if.m_end = 1'b0;
        repeat (lat) @(negedge iCLK);
        if (nack_left > 0) begin
          m_if.m_ack = 1'b1;
          nack_left--;
        end else begin
          m_if.m_ack = 1'b0;
        end
        m_if.m_end = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns the number of negedges until a grant appears (or the budget).
  task automatic wait_grant(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge iCLK);
      cyc++;
    end while ((req_grant == 2'b00) && (cyc < budget));
  endtask

  // Called on the grant negedge; returns negedges until req_done appears and
  // records START rises, shortest low run between rises and stray grants.
  task automatic wait_done(input int budget, output int cyc);
    logic prev;
    int   cur_low;
    cyc         = 0;
    rises       = 1;
    min_low     = 1000;
    grants_seen = 0;
    cur_low     = 0;
    prev        = m_if.m_start;
    do begin
      @(negedge iCLK);
      cyc++;
      if (m_if.m_start && !prev) begin
        rises++;
        if (cur_low < min_low) min_low = cur_low;
      end
      cur_low = m_if.m_start ? 0 : cur_low + 1;
      prev    = m_if.m_start;
      if (req_grant != 2'b00) grants_seen++;
    end while ((req_done == 2'b00) && (cyc < budget));
  endtask

  initial begin
    int          c;
    int          k;
    logic [1:0]  exp_g;

    req_valid = 2'b00;
    req0_data = D0;
    req1_data = D1;

    // ---------------- reset values ----------------
    repeat (3) @(negedge iCLK);
    check("rst_m_start", 32'(m_if.m_start), 0);
    check("rst_m_data",  32'(m_if.m_data),  0);
    check("rst_grant",   32'(req_grant),    0);
    check("rst_done",    32'(req_done),     0);
    check("rst_err_tmo", {30'd0, req_err, req_tmo}, 0);
    check("rst_busy",    32'(busy),         0);
    check("rst_err_cnt", 32'(err_cnt),      0);
    check("rst_owner",   32'(owner),        1);
    iRST_N = 1'b1;
    @(negedge iCLK);

    // ---------------- both requesting: round robin 0,1,0,1 ----------------
    lat = 3;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      wait_grant(20, c);
      check("rr_grant_lat", 32'(c), 1);
      check("rr_grant",     32'(req_grant), 32'(exp_g));
      check("rr_m_data",    32'(m_if.m_data), 32'((i % 2 == 0) ? D0 : D1));
      check("rr_owner",     32'(owner), 32'(i % 2));
      wait_done(50, c);
      check("rr_done_lat",  32'(c), 4);
      check("rr_done",      32'(req_done), 32'(exp_g));
      check("rr_err",       32'(req_err), 0);
      check("rr_busy_gap",  32'(busy), 0);
      check("rr_no_grant",  32'(grants_seen), 0);
    end
    req_valid = 2'b00;
    @(negedge iCLK);
    check("rr_idle_busy",  32'(busy), 0);
    check("rr_idle_grant", 32'(req_grant), 0);

    // ---------------- single req0, ACK after 100 cycles ----------------
    lat = 100;
    req_valid = 2'b01;
    wait_grant(20, c);
    check("s0_grant_lat", 32'(c), 1);
    check("s0_grant",     32'(req_grant), 32'(2'b01));
    check("s0_m_start",   32'(m_if.m_start), 1);
    check("s0_m_data",    32'(m_if.m_data), 32'(D0));
    check("s0_busy",      32'(busy), 1);
    req_valid = 2'b00;
    wait_done(200, c);
    check("s0_done_lat",  32'(c), 101);
    check("s0_done",      32'(req_done), 32'(2'b01));
    check("s0_err_tmo",   {30'd0, req_err, req_tmo}, 0);
    check("s0_m_data_hold", 32'(m_if.m_data), 32'(D0));
    @(negedge iCLK);
    check("s0_busy_after", 32'(busy), 0);
    check("s0_done_once",  32'(req_done), 0);

    // ---------------- req1, 3 NACKs then ACK ----------------
    lat = 1;
    nack_left = 3;
    req_valid = 2'b10;
    wait_grant(20, c);
    check("r1_grant", 32'(req_grant), 32'(2'b10));
    req_valid = 2'b00;
    wait_done(100, c);
    check("r1_done_lat", 32'(c), 11);
    check("r1_starts",   32'(rises), 4);
    check("r1_min_gap",  32'(min_low), 2);
    check("r1_done",     32'(req_done), 32'(2'b10));
    check("r1_err",      32'(req_err), 0);
    check("r1_err_cnt",  32'(err_cnt), 0);
    @(negedge iCLK);
    check("r1_done_once", 32'(req_done), 0);

    // ---------------- req0, always NACK ----------------
    lat = 1;
    nack_left = 100;
    req_valid = 2'b01;
    wait_grant(20, c);
    check("nk_grant", 32'(req_grant), 32'(2'b01));
    req_valid = 2'b00;
    wait_done(100, c);
    check("nk_done_lat", 32'(c), 11);
    check("nk_starts",   32'(rises), 4);
    check("nk_done",     32'(req_done), 32'(2'b01));
    check("nk_err_tmo",  {30'd0, req_err, req_tmo}, 32'b10);
    check("nk_err_cnt",  32'(err_cnt), 1);
    @(negedge iCLK);
    check("nk_err_hold", 32'(req_err), 1);
    nack_left = 0;

    // ---------------- timeout, then req1 blocked during DRAIN ----------------
    lat = 200;
    req_valid = 2'b01;
    wait_grant(20, c);
    check("to_grant",    32'(req_grant), 32'(2'b01));
    check("to_err_held", 32'(req_err), 1);
    req_valid = 2'b00;
    wait_done(400, c);
    check("to_done_lat", 32'(c), TIMEOUT);
    check("to_done",     32'(req_done), 32'(2'b01));
    check("to_err_tmo",  {30'd0, req_err, req_tmo}, 32'b11);
    check("to_err_cnt",  32'(err_cnt), 2);
    check("to_m_start",  32'(m_if.m_start), 0);
    check("to_busy",     32'(busy), 1);
    lat = 3;
    req_valid = 2'b10;
    wait_grant(100, c);
    check("dr_grant_lat", 32'(c), 52);
    check("dr_grant",     32'(req_grant), 32'(2'b10));
    req_valid = 2'b00;
    wait_done(50, c);
    check("dr_done_lat",  32'(c), 4);
    check("dr_done",      32'(req_done), 32'(2'b10));
    check("dr_err_tmo",   {30'd0, req_err, req_tmo}, 0);

    // ---------------- asynchronous reset mid-WAIT ----------------
    lat = 50;
    req_valid = 2'b01;
    wait_grant(20, c);
    check("ar_grant", 32'(req_grant), 32'(2'b01));
    req_valid = 2'b00;
    repeat (10) @(negedge iCLK);
    check("ar_busy_pre", 32'(busy), 1);
    #2 iRST_N = 1'b0;
    #1;
    check("ar_m_start", 32'(m_if.m_start), 0);
    check("ar_busy",    32'(busy), 0);
    check("ar_err_cnt", 32'(err_cnt), 0);
    check("ar_owner",   32'(owner), 1);
    check("ar_done",    32'(req_done), 0);
    k = 0;
    while ((m_if.m_end == 1'b0) && (k < 100)) begin
      @(negedge iCLK);
      k++;
    end
    check("ar_master_idle", 32'(m_if.m_end), 1);
    check("ar_no_done", 32'(req_done), 0);
    lat = 3;
    iRST_N = 1'b1;
    @(negedge iCLK);
    req_valid = 2'b11;
    wait_grant(20, c);
    check("ar_tie_lat",   32'(c), 1);
    check("ar_tie_grant", 32'(req_grant), 32'(2'b01));
    req_valid = 2'b00;
    wait_done(50, c);
    check("ar_done_lat",  32'(c), 4);
    check("ar_done_0",    32'(req_done), 32'(2'b01));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
